// File: rtl/prog_loader_if.sv
// Loader-side bundle: UART RX byte strobe in, instruction-memory write port and
// core release/status out. The loader drives through master; its peer uses slave.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata, core_reset, done, error
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata, core_reset, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses MAGIC/LEN/data/CSUM frames, writes
// little-endian 32-bit words into imem and releases the core on a good checksum.
module prog_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.master bus
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    RUN,
    ERROR
  } state_t;

  state_t            state, state_n;
  logic [7:0]        len_lo, len_lo_n;
  logic [ADDR_W-1:0] last_word, last_n;
  logic [ADDR_W-1:0] word_idx, widx_n;
  logic [1:0]        byte_idx, bidx_n;
  logic [31:0]       asm_q, asm_n;
  logic [7:0]        csum, csum_n;
  logic [16:0]       len_full;

  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic              crst_q, crst_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_lo    <= '0;
      last_word <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
      csum      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      crst_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      len_lo    <= len_lo_n;
      last_word <= last_n;
      word_idx  <= widx_n;
      byte_idx  <= bidx_n;
      asm_q     <= asm_n;
      csum      <= csum_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      crst_q    <= crst_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  // Outputs are computed here as next-values and registered above, so every
  // output changes exactly one cycle after the byte that caused it.
  always_comb begin
    state_n  = state;
    len_lo_n = len_lo;
    last_n   = last_word;
    widx_n   = word_idx;
    bidx_n   = byte_idx;
    asm_n    = asm_q;
    csum_n   = csum;
    we_n     = 1'b0;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    crst_n   = crst_q;
    done_n   = done_q;
    err_n    = err_q;
    len_full = {1'b0, bus.rx_data, len_lo};

    if (bus.rx_valid) begin
      unique case (state)
        IDLE: begin
          if (bus.rx_data == MAGIC) begin
            state_n = LEN_LO;
            crst_n  = 1'b1;
            done_n  = 1'b0;
            err_n   = 1'b0;
            csum_n  = '0;
          end
        end
        LEN_LO: begin
          len_lo_n = bus.rx_data;
          state_n  = LEN_HI;
        end
        LEN_HI: begin
          if (len_full > DEPTH) begin
            state_n = ERROR;
            err_n   = 1'b1;
            crst_n  = 1'b1;
          end else if (len_full == '0) begin
            state_n = CSUM;
            csum_n  = '0;
          end else begin
            state_n = DATA;
            last_n  = ADDR_W'(len_full - 17'd1);
            widx_n  = '0;
            bidx_n  = '0;
            csum_n  = '0;
          end
        end
        DATA: begin
          asm_n[8*byte_idx +: 8] = bus.rx_data;
          csum_n = csum + bus.rx_data;
          bidx_n = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            we_n    = 1'b1;
            addr_n  = word_idx;
            wdata_n = asm_n;
            widx_n  = word_idx + ADDR_W'(1);
            if (word_idx == last_word) state_n = CSUM;
          end
        end
        CSUM: begin
          if (bus.rx_data == csum) begin
            state_n = RUN;
            crst_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ERROR;
            err_n   = 1'b1;
            crst_n  = 1'b1;
          end
        end
        RUN: begin
          if (bus.rx_data == MAGIC) begin
            state_n = LEN_LO;
            crst_n  = 1'b1;
            done_n  = 1'b0;
            csum_n  = '0;
          end
        end
        ERROR: begin
          if (bus.rx_data == MAGIC) begin
            state_n = LEN_LO;
            err_n   = 1'b0;
            csum_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_reset = crst_q;
  assign bus.done       = done_q;
  assign bus.error      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frame senders push expected imem writes,
// a negedge monitor pops and compares address, data and write cycle.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  wr_t         sb[$];
  wr_t         e;
  logic [31:0] words[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every imem_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.imem_we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%0h data=%h cyc=%0d, expected no write",
                 bus.imem_addr, bus.imem_wdata, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL imem_write: got addr=%0h data=%h cyc=%0d, expected addr=%0h data=%h cyc=%0d",
                   bus.imem_addr, bus.imem_wdata, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic cr, input logic er);
    check({tag, "_done"}, 32'(bus.done), 32'(d));
    check({tag, "_core_reset"}, 32'(bus.core_reset), 32'(cr));
    check({tag, "_error"}, 32'(bus.error), 32'(er));
  endtask

  // Caller is always #1 after a posedge; returns in the same phase.
  task automatic send_byte(input logic [7:0] b, input int idle);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (idle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int idle, input logic [7:0] csum, input bit reload_chk);
    logic [15:0] len;
    logic [31:0] w;
    wr_t         x;
    len = 16'(words.size());
    send_byte(8'hA5, idle);
    if (reload_chk) begin
      check("reload_core_reset", 32'(bus.core_reset), 32'd1);
      check("reload_done", 32'(bus.done), 32'd0);
    end
    send_byte(len[7:0], idle);
    send_byte(len[15:8], idle);
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int k = 0; k < 4; k++) begin
        if (k == 3) begin
          x.addr = ADDR_W'(i);
          x.data = w;
          x.cyc  = cyc + 1;
          sb.push_back(x);
        end
        send_byte(w[8*k +: 8], idle);
      end
    end
    send_byte(csum, idle);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  sum;
    logic [31:0] w;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("rst_imem_we", 32'(bus.imem_we), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check_status("rst", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(8'h00, 2);

    // Single-word load, back-to-back bytes
    words = '{32'h00000513};
    send_frame(0, 8'h18, 1'b0);
    check_status("single", 1'b1, 1'b0, 1'b0);

    // Two words with 3 idle cycles between bytes, reloading from RUN
    words = '{32'h00100093, 32'h00200113};
    send_frame(3, 8'hD7, 1'b1);
    check_status("two_word", 1'b1, 1'b0, 1'b0);

    // Bad checksum: the write still lands, then error
    words = '{32'h00000513};
    send_frame(0, 8'h19, 1'b0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1);
    send_frame(1, 8'h18, 1'b0);
    check_status("after_bad", 1'b1, 1'b0, 1'b0);

    // Length overflow: 257 words with ADDR_W=8
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_status("overflow", 1'b0, 1'b1, 1'b1);
    send_byte(8'h77, 1);
    check_status("overflow_ignore", 1'b0, 1'b1, 1'b1);

    // Zero-length image
    words = '{};
    send_frame(0, 8'h00, 1'b0);
    check_status("len0", 1'b1, 1'b0, 1'b0);

    // Full-capacity image: 256 words, last address 255
    words = '{};
    sum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = (32'(i) * 32'h01030507) ^ 32'h5A5A0000;
      words.push_back(w);
      for (int k = 0; k < 4; k++) sum = sum + w[8*k +: 8];
    end
    send_frame(0, sum, 1'b1);
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_last_addr", 32'(bus.imem_addr), 32'hFF);

    // Mid-frame asynchronous reset after two data bytes
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_imem_we", 32'(bus.imem_we), 32'd0);
    check("midrst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("midrst_imem_wdata", bus.imem_wdata, 32'd0);
    check_status("midrst", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    check_status("stray", 1'b0, 1'b1, 1'b0);
    words = '{32'h00000513};
    send_frame(0, 8'h18, 1'b0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
